// File: rtl/byte_stream_serializer.sv
// Captures one packed BIT_LENGTH-bit block and streams it out little-endian,
// one byte per accepted cycle, on a valid/ready byte interface.
module byte_stream_serializer #(
  parameter int BIT_LENGTH  = 2048,
  parameter int BYTE_LENGTH = BIT_LENGTH / 8,
  parameter int IDX_W       = $clog2(BYTE_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH-1:0] in_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_LENGTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_index;
  logic [IDX_W-1:0]      w_index_next;
  logic [BIT_LENGTH-1:0] r_block;
  logic                  w_load;
  logic                  w_at_last;
  logic [7:0]            w_bytes [BYTE_LENGTH];

  // Byte gi of the held block is bits [8gi+7:8gi].
  generate
    for (genvar gi = 0; gi < BYTE_LENGTH; gi++) begin : g_bytes
      assign w_bytes[gi] = r_block[8*gi +: 8];
    end
  endgenerate

  assign w_at_last = (r_index == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_load       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        w_load   = in_valid & ~rst;
        if (w_load) begin
          w_state_next = STREAM;
          w_index_next = '0;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (w_at_last) begin
            w_state_next = IDLE;
            w_index_next = '0;
          end else begin
            w_index_next = r_index + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_index_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_index <= '0;
      r_block <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      if (w_load) begin
        r_block <= in_bits;
      end
    end
  end

  // All byte-side outputs come straight from registered state, so they hold
  // steady under backpressure.
  assign out_byte  = w_bytes[r_index];
  assign out_index = r_index;
  assign out_last  = (r_state == STREAM) & w_at_last;
  assign busy      = (r_state == STREAM);

endmodule

// File: tb/tb_byte_stream_serializer.sv
// Self-checking bench for byte_stream_serializer: a vector table for reset and
// load corners, then whole-block streams checked against a byte-slice model.
module tb_byte_stream_serializer;

  localparam int BIT_LENGTH  = 2048;
  localparam int BYTE_LENGTH = BIT_LENGTH / 8;
  localparam int IDX_W       = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_LENGTH-1:0] in_bits;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_byte;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]            exp_bytes [BYTE_LENGTH];
  logic [BIT_LENGTH-1:0] blk_a;
  logic [BIT_LENGTH-1:0] blk_b;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic       exp_busy;
    logic       exp_last;
    logic [7:0] exp_idx;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vt [9];

  always #5 clk = ~clk;

  byte_stream_serializer #(
    .BIT_LENGTH (BIT_LENGTH),
    .BYTE_LENGTH(BYTE_LENGTH),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bits  (in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte i of a block is its i-th least-significant octet.
  function automatic void model_bytes(input logic [BIT_LENGTH-1:0] blk);
    for (int i = 0; i < BYTE_LENGTH; i++) begin
      exp_bytes[i] = 8'(blk >> (8 * i));
    end
  endfunction

  function automatic logic [BIT_LENGTH-1:0] rand_block();
    logic [BIT_LENGTH-1:0] b;
    for (int w = 0; w < BIT_LENGTH / 32; w++) begin
      b[32*w +: 32] = $urandom;
    end
    return b;
  endfunction

  // Loads blk from IDLE and consumes the stream. mode: 0 ready always,
  // 1 ready 1-high/2-low, 2 random ready. abort_at >= 0 pulses rst at that index.
  // hold keeps in_valid high with next_blk on in_bits during the stream.
  task automatic run_stream(input logic [BIT_LENGTH-1:0] blk, input int mode,
                            input int abort_at, input bit hold,
                            input logic [BIT_LENGTH-1:0] next_blk);
    int   i   = 0;
    int   cyc = 0;
    logic rdy;
    in_bits   = blk;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    if (hold) begin
      in_bits = next_blk;
    end else begin
      in_valid = 1'b0;
      in_bits  = ~blk;
    end
    chk("load_busy", 32'(busy), 32'd1);
    while (i < BYTE_LENGTH && cyc < 4 * BYTE_LENGTH) begin
      if (i == abort_at) begin
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        $display("block aborted by reset at index %0d", i);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_byte", 32'(out_byte), 32'(exp_bytes[i]));
      chk("out_index", 32'(out_index), 32'(i));
      chk("out_last", 32'(out_last), 32'(i == BYTE_LENGTH - 1));
      chk("stream_in_ready", 32'(in_ready), 32'd0);
      step();
      cyc++;
      if (rdy) i++;
    end
    out_ready = 1'b0;
    if (i < BYTE_LENGTH) chk("stream_timeout", 32'(i), 32'(BYTE_LENGTH));
    if (mode == 0) chk("stream_cycles", 32'(cyc), 32'(BYTE_LENGTH));
    chk("end_out_valid", 32'(out_valid), 32'd0);
    chk("end_in_ready", 32'(in_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    $display("block done: mode %0d, %0d bytes in %0d cycles", mode, i, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < BYTE_LENGTH; i++) in_bits[8*i +: 8] = 8'(8'h10 + i);

    //          rst   iv    ordy  ir    ov    busy  last  idx    byte
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'h10};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'h10};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'h11};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'h12};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};

    for (int v = 0; v < 9; v++) begin
      rst       = vt[v].rst;
      in_valid  = vt[v].iv;
      out_ready = vt[v].ordy;
      step();
      chk("vec_in_ready", 32'(in_ready), 32'(vt[v].exp_ir));
      chk("vec_out_valid", 32'(out_valid), 32'(vt[v].exp_ov));
      chk("vec_busy", 32'(busy), 32'(vt[v].exp_busy));
      chk("vec_out_last", 32'(out_last), 32'(vt[v].exp_last));
      chk("vec_out_index", 32'(out_index), 32'(vt[v].exp_idx));
      chk("vec_out_byte", 32'(out_byte), 32'(vt[v].exp_byte));
      $display("vector %0d: rst=%0b in_valid=%0b out_ready=%0b -> idx=%0d byte=%02h",
               v, vt[v].rst, vt[v].iv, vt[v].ordy, out_index, out_byte);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // MSB-first concatenation 01,02,...,FF,00 -> emitted 00,FF,FE,...,01.
    for (int k = 0; k < BYTE_LENGTH; k++) blk_a[BIT_LENGTH-1-8*k -: 8] = 8'(k + 1);
    for (int i = 0; i < BYTE_LENGTH; i++) exp_bytes[i] = 8'(BYTE_LENGTH - i);
    run_stream(blk_a, 0, -1, 1'b0, '0);
    run_stream(blk_a, 1, -1, 1'b0, '0);

    // All-A5 block with a competing block held on the input throughout.
    blk_a = {BYTE_LENGTH{8'hA5}};
    blk_b = rand_block();
    for (int i = 0; i < BYTE_LENGTH; i++) exp_bytes[i] = 8'hA5;
    run_stream(blk_a, 0, -1, 1'b1, blk_b);
    model_bytes(blk_b);
    run_stream(blk_b, 0, -1, 1'b0, '0);

    // Reset mid-stream, then a fresh block must start from byte 0.
    blk_a = rand_block();
    model_bytes(blk_a);
    run_stream(blk_a, 0, 37, 1'b0, '0);
    blk_b = rand_block();
    model_bytes(blk_b);
    run_stream(blk_b, 2, -1, 1'b0, '0);

    for (int r = 0; r < 3; r++) begin
      blk_a = rand_block();
      model_bytes(blk_a);
      run_stream(blk_a, 2, -1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
